// File: rtl/control_pkg.sv
// Shared encodings for the ARM sequencer: controller states, ALU operation
// codes, condition codes and the data-path select values.
package control_pkg;

  typedef enum logic [4:0] {
    RESET   = 5'd0,
    FETCH1  = 5'd1,
    FETCH2  = 5'd2,
    FETCH3  = 5'd3,
    FETCH4  = 5'd4,
    DECODE  = 5'd5,
    DP      = 5'd6,
    LS_ADDR = 5'd7,
    LD_REQ  = 5'd8,
    LD_WB   = 5'd9,
    ST_DATA = 5'd10,
    ST_REQ  = 5'd11,
    BL_LINK = 5'd12,
    BR      = 5'd13
  } state_t;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0010;
  localparam logic [3:0] ALU_ADD    = 4'b0100;
  localparam logic [3:0] ALU_MOV    = 4'b1101;
  localparam logic [3:0] ALU_PASS_A = 4'b1111;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  localparam logic [1:0] WRA_RD  = 2'd0;
  localparam logic [1:0] WRA_R15 = 2'd1;
  localparam logic [1:0] WRA_R14 = 2'd2;
  localparam logic [1:0] WRA_RN  = 2'd3;

  localparam logic [1:0] SRA_RN  = 2'd0;
  localparam logic [1:0] SRA_R15 = 2'd1;
  localparam logic [1:0] SRA_R14 = 2'd2;
  localparam logic [1:0] SRA_RD  = 2'd3;

  localparam logic [1:0] SRB_RN  = 2'd0;
  localparam logic [1:0] SRB_R15 = 2'd1;
  localparam logic [1:0] SRB_RD  = 2'd2;
  localparam logic [1:0] SRB_RM  = 2'd3;

  localparam logic [1:0] SISE_ROT8  = 2'd0;
  localparam logic [1:0] SISE_IMM12 = 2'd1;

  localparam logic [1:0] SALUB_MDR     = 2'd0;
  localparam logic [1:0] SALUB_FOUR    = 2'd1;
  localparam logic [1:0] SALUB_BRANCH  = 2'd2;
  localparam logic [1:0] SALUB_SHIFTER = 2'd3;

  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_WORD = 2'b10;

endpackage

// File: rtl/control_unit_cond_check.sv
// ARM condition-field evaluator: decides whether an instruction executes
// given its condition code and the current N/Z/C/V flags.
module cond_check
  import control_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign n = flags[3];
  assign z = flags[2];
  assign c = flags[1];
  assign v = flags[0];

  always_comb begin
    pass = 1'b0;
    case (cond_t'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the ARM data path: fetch, decode and execute of the
// data-processing, immediate load/store and branch subset.
module control_unit
  import control_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR,
  input  logic [31:0] IR,
  input  logic        MFC,
  input  logic [3:0]  Flags,
  output logic        MFA,
  output logic        RW_RAM,
  output logic        RF_RW,
  output logic        MAR_EN,
  output logic        MDR_EN,
  output logic        IR_EN,
  output logic        SR_EN,
  output logic        SHT_EN,
  output logic        ISE_EN,
  output logic        SGN_EN,
  output logic        SALU,
  output logic        SSAB,
  output logic        SSOP,
  output logic        SMA,
  output logic        STA,
  output logic [1:0]  DataSize,
  output logic [1:0]  WRA,
  output logic [1:0]  SRA,
  output logic [1:0]  SRB,
  output logic [1:0]  SISE,
  output logic [1:0]  SALUB,
  output logic [3:0]  ALUA,
  output logic [4:0]  State
);

  state_t     stateReg, stateNext;
  logic       condPass;
  logic [1:0] lsSize;
  logic       unusedIr;

  // Writeback bit and the low operand fields are consumed by the data path only.
  assign unusedIr = ^{IR[21], IR[19:0]};

  cond_check condCheck (
    .cond  (IR[31:28]),
    .flags (Flags),
    .pass  (condPass)
  );

  assign lsSize = IR[22] ? DSIZE_BYTE : DSIZE_WORD;
  assign State  = stateReg;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) stateReg <= RESET;
    else     stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      RESET:   stateNext = FETCH1;
      FETCH1:  stateNext = FETCH2;
      FETCH2:  stateNext = FETCH3;
      FETCH3:  if (MFC) stateNext = FETCH4;
      FETCH4:  stateNext = DECODE;
      DECODE: begin
        // Unsupported encodings fall back to fetch, behaving as a NOP.
        if (!condPass)                  stateNext = FETCH1;
        else if (IR[27:26] == 2'b00)    stateNext = DP;
        else if (IR[27:25] == 3'b010)   stateNext = LS_ADDR;
        else if (IR[27:25] == 3'b101)   stateNext = IR[24] ? BL_LINK : BR;
        else                            stateNext = FETCH1;
      end
      DP:      stateNext = FETCH1;
      LS_ADDR: stateNext = IR[20] ? LD_REQ : ST_DATA;
      LD_REQ:  if (MFC) stateNext = LD_WB;
      LD_WB:   stateNext = FETCH1;
      ST_DATA: stateNext = ST_REQ;
      ST_REQ:  if (MFC) stateNext = FETCH1;
      BL_LINK: stateNext = BR;
      BR:      stateNext = FETCH1;
      default: stateNext = RESET;
    endcase
  end

  always_comb begin
    MFA      = 1'b0;
    RW_RAM   = 1'b0;
    RF_RW    = 1'b0;
    MAR_EN   = 1'b0;
    MDR_EN   = 1'b0;
    IR_EN    = 1'b0;
    SR_EN    = 1'b0;
    SHT_EN   = 1'b0;
    ISE_EN   = 1'b0;
    SGN_EN   = 1'b0;
    SALU     = 1'b0;
    SSAB     = 1'b0;
    SSOP     = 1'b0;
    SMA      = 1'b0;
    STA      = 1'b0;
    DataSize = DSIZE_BYTE;
    WRA      = WRA_RD;
    SRA      = SRA_RN;
    SRB      = SRB_RN;
    SISE     = SISE_ROT8;
    SALUB    = SALUB_MDR;
    ALUA     = ALU_AND;
    case (stateReg)
      FETCH1: begin
        SRA    = SRA_R15;
        ALUA   = ALU_PASS_A;
        MAR_EN = 1'b1;
      end
      FETCH2: begin
        SRA   = SRA_R15;
        SALUB = SALUB_FOUR;
        ALUA  = ALU_ADD;
        WRA   = WRA_R15;
        RF_RW = 1'b1;
      end
      FETCH3: begin
        MFA      = 1'b1;
        RW_RAM   = 1'b1;
        DataSize = DSIZE_WORD;
        SMA      = 1'b1;
        MDR_EN   = 1'b1;
      end
      FETCH4: IR_EN = 1'b1;
      DP: begin
        SALU   = 1'b1;
        SRA    = SRA_RN;
        SALUB  = SALUB_SHIFTER;
        SHT_EN = 1'b1;
        SSOP   = ~IR[25];
        SRB    = SRB_RM;
        ISE_EN = IR[25];
        SISE   = SISE_ROT8;
        SR_EN  = IR[20];
        // Compare/test opcodes only update flags.
        RF_RW  = (IR[24:23] != 2'b10);
        WRA    = WRA_RD;
      end
      LS_ADDR: begin
        ALUA   = IR[23] ? ALU_ADD : ALU_SUB;
        SALUB  = SALUB_SHIFTER;
        ISE_EN = 1'b1;
        SISE   = SISE_IMM12;
        SHT_EN = 1'b1;
        MAR_EN = 1'b1;
      end
      LD_REQ: begin
        MFA      = 1'b1;
        RW_RAM   = 1'b1;
        DataSize = lsSize;
        SMA      = 1'b1;
        MDR_EN   = 1'b1;
        SGN_EN   = 1'b1;
      end
      LD_WB: begin
        SALUB = SALUB_MDR;
        ALUA  = ALU_MOV;
        WRA   = WRA_RD;
        RF_RW = 1'b1;
      end
      ST_DATA: begin
        SRB    = SRB_RD;
        SSOP   = 1'b1;
        SHT_EN = 1'b1;
        SALUB  = SALUB_SHIFTER;
        ALUA   = ALU_MOV;
        MDR_EN = 1'b1;
      end
      ST_REQ: begin
        MFA      = 1'b1;
        DataSize = lsSize;
      end
      BL_LINK: begin
        SRA   = SRA_R15;
        ALUA  = ALU_PASS_A;
        WRA   = WRA_R14;
        RF_RW = 1'b1;
      end
      BR: begin
        SRA   = SRA_R15;
        SALUB = SALUB_BRANCH;
        ALUA  = ALU_ADD;
        WRA   = WRA_R15;
        RF_RW = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instructions plus randomized instruction
// streams checked cycle by cycle against an instruction-level trace model.
module tb_control_unit;
  import control_pkg::*;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [31:0] IR;
  logic        MFC;
  logic [3:0]  Flags;
  logic        MFA, RW_RAM, RF_RW, MAR_EN, MDR_EN, IR_EN, SR_EN, SHT_EN;
  logic        ISE_EN, SGN_EN, SALU, SSAB, SSOP, SMA, STA;
  logic [1:0]  DataSize, WRA, SRA, SRB, SISE, SALUB;
  logic [3:0]  ALUA;
  logic [4:0]  State;

  control_unit dut (
    .CLK(CLK), .CLR(CLR), .IR(IR), .MFC(MFC), .Flags(Flags),
    .MFA(MFA), .RW_RAM(RW_RAM), .RF_RW(RF_RW), .MAR_EN(MAR_EN),
    .MDR_EN(MDR_EN), .IR_EN(IR_EN), .SR_EN(SR_EN), .SHT_EN(SHT_EN),
    .ISE_EN(ISE_EN), .SGN_EN(SGN_EN), .SALU(SALU), .SSAB(SSAB),
    .SSOP(SSOP), .SMA(SMA), .STA(STA), .DataSize(DataSize), .WRA(WRA),
    .SRA(SRA), .SRB(SRB), .SISE(SISE), .SALUB(SALUB), .ALUA(ALUA),
    .State(State)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       mfa, rwRam, rfRw, marEn, mdrEn, irEn, srEn, shtEn;
    logic       iseEn, salu, ssop, sma;
    logic [1:0] dataSize, wra, salub, sra, srb, sise;
  } obs_t;

  int     vectors = 0;
  int     miscompares = 0;
  int     mfcCnt = 0;
  int     mfcDelay = 1;
  state_t expQ[$];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (ir %h, t=%0t)", tag, got, exp, IR, $time);
    end
  endtask

  function automatic obs_t sampleObs();
    obs_t o;
    o = '{mfa: MFA, rwRam: RW_RAM, rfRw: RF_RW, marEn: MAR_EN, mdrEn: MDR_EN,
          irEn: IR_EN, srEn: SR_EN, shtEn: SHT_EN, iseEn: ISE_EN, salu: SALU,
          ssop: SSOP, sma: SMA, dataSize: DataSize, wra: WRA, salub: SALUB,
          sra: SRA, srb: SRB, sise: SISE};
    return o;
  endfunction

  // Condition codes come in complementary pairs; the low bit inverts the base test.
  function automatic bit refCond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c[0] == 1'b0);
    endcase
    return base ^ c[0];
  endfunction

  // Expected state trace of one instruction, starting at its FETCH1.
  task automatic buildTrace(input logic [31:0] ir, input logic [3:0] f, input int d);
    expQ.delete();
    expQ.push_back(FETCH1);
    expQ.push_back(FETCH2);
    repeat (d + 1) expQ.push_back(FETCH3);
    expQ.push_back(FETCH4);
    expQ.push_back(DECODE);
    if (!refCond(ir[31:28], f)) return;
    if (ir[27:26] == 2'b00) expQ.push_back(DP);
    else if (ir[27:25] == 3'b010) begin
      expQ.push_back(LS_ADDR);
      if (ir[20]) begin
        repeat (d + 1) expQ.push_back(LD_REQ);
        expQ.push_back(LD_WB);
      end else begin
        expQ.push_back(ST_DATA);
        repeat (d + 1) expQ.push_back(ST_REQ);
      end
    end else if (ir[27:25] == 3'b101) begin
      if (ir[24]) expQ.push_back(BL_LINK);
      expQ.push_back(BR);
    end
  endtask

  function automatic obs_t expObs(input state_t s, input logic [31:0] ir);
    obs_t o = '0;
    logic [1:0] sz = ir[22] ? 2'b00 : 2'b10;
    case (s)
      FETCH1:  begin o.sra = 2'd1; o.marEn = 1'b1; end
      FETCH2:  begin o.sra = 2'd1; o.salub = 2'd1; o.wra = 2'd1; o.rfRw = 1'b1; end
      FETCH3:  begin o.mfa = 1; o.rwRam = 1; o.dataSize = 2'b10; o.sma = 1; o.mdrEn = 1; end
      FETCH4:  o.irEn = 1'b1;
      DP: begin
        o.salu = 1; o.salub = 2'd3; o.shtEn = 1; o.ssop = ~ir[25]; o.srb = 2'd3;
        o.iseEn = ir[25]; o.srEn = ir[20]; o.rfRw = (ir[24:23] != 2'b10);
      end
      LS_ADDR: begin o.salub = 2'd3; o.iseEn = 1; o.sise = 2'd1; o.shtEn = 1; o.marEn = 1; end
      LD_REQ:  begin o.mfa = 1; o.rwRam = 1; o.dataSize = sz; o.sma = 1; o.mdrEn = 1; end
      LD_WB:   o.rfRw = 1'b1;
      ST_DATA: begin o.srb = 2'd2; o.ssop = 1; o.shtEn = 1; o.salub = 2'd3; o.mdrEn = 1; end
      ST_REQ:  begin o.mfa = 1; o.dataSize = sz; end
      BL_LINK: begin o.sra = 2'd1; o.wra = 2'd2; o.rfRw = 1'b1; end
      BR:      begin o.sra = 2'd1; o.salub = 2'd2; o.wra = 2'd1; o.rfRw = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  // -1 marks states where the ALU code is a don't-care.
  function automatic int expAlu(input state_t s, input logic [31:0] ir);
    case (s)
      RESET:           return 0;
      FETCH1, BL_LINK: return 15;
      FETCH2, BR:      return 4;
      LS_ADDR:         return ir[23] ? 4 : 2;
      LD_WB, ST_DATA:  return 13;
      default:         return -1;
    endcase
  endfunction

  // Memory model: MFC answers mfcDelay+1 cycles into a request, random outside one.
  task automatic driveMfc();
    if (MFA) begin
      mfcCnt++;
      MFC = (mfcCnt > mfcDelay);
    end else begin
      mfcCnt = 0;
      MFC = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic checkCycle(input string tag, input state_t s, input logic [31:0] ir);
    int ea;
    checkVal({tag, "_state"}, 32'(State), 32'(s));
    checkVal({tag, "_outs"}, 32'(sampleObs()), 32'(expObs(s, ir)));
    ea = expAlu(s, ir);
    if (ea >= 0) checkVal({tag, "_alua"}, 32'(ALUA), 32'(ea));
  endtask

  task automatic runInstr(input string tag, input logic [31:0] ir, input logic [3:0] f, input int d);
    buildTrace(ir, f, d);
    $display("instr %-8s ir=%h flags=%b mfcDelay=%0d cycles=%0d", tag, ir, f, d, expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      @(negedge CLK);
      checkCycle(tag, expQ[i], ir);
      if (i == 0) begin
        IR = ir;
        Flags = f;
        mfcDelay = d;
      end
      driveMfc();
    end
  endtask

  initial begin
    CLR = 1'b1;
    IR = '0;
    MFC = 1'b0;
    Flags = '0;
    @(negedge CLK);
    checkCycle("reset", RESET, IR);
    CLR = 1'b0;

    runInstr("mov", 32'hE3A01005, 4'b0000, 1);
    runInstr("beq_nt", 32'h0A000002, 4'b0000, 1);
    runInstr("beq_t", 32'h0A000002, 4'b0100, 1);
    runInstr("ldr", 32'hE5912004, 4'b0000, 3);
    runInstr("strb", 32'hE5C12000, 4'b0000, 1);
    runInstr("bl", 32'hEB000010, 4'b0000, 1);
    runInstr("cmp", 32'hE1510002, 4'b0000, 0);

    // Asynchronous clear in the middle of an instruction fetch.
    IR = 32'hE3A01005;
    mfcDelay = 3;
    @(negedge CLK); checkVal("clr_f1", 32'(State), 32'(FETCH1)); driveMfc();
    @(negedge CLK); checkVal("clr_f2", 32'(State), 32'(FETCH2)); driveMfc();
    @(negedge CLK); checkVal("clr_f3", 32'(State), 32'(FETCH3));
    checkVal("clr_mfa_pre", 32'(MFA), 32'd1);
    driveMfc();
    #2 CLR = 1'b1;
    #1;
    checkVal("clr_mfa", 32'(MFA), 32'd0);
    checkVal("clr_state", 32'(State), 32'(RESET));
    checkVal("clr_outs", 32'(sampleObs()), 32'd0);
    @(negedge CLK);
    checkVal("clr_hold", 32'(State), 32'(RESET));
    CLR = 1'b0;
    mfcCnt = 0;
    MFC = 1'b0;
    runInstr("post_clr", 32'hE5D12001, 4'b0000, 2);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] body, ir;
      logic [3:0]  cond;
      logic [2:0]  undef [4];
      undef = '{3'b011, 3'b100, 3'b110, 3'b111};
      body = $urandom;
      cond = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0, 4:    ir = {cond, 2'b00, body[25:0]};
        1, 5:    ir = {cond, 3'b010, body[24:0]};
        2:       ir = {cond, 3'b101, body[24:0]};
        default: ir = {cond, undef[$urandom_range(0, 3)], body[24:0]};
      endcase
      runInstr("rand", ir, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
